// File: rtl/tc_loader_pkg.sv
// -----------------------------------------------------------------------------
// tc_loader_pkg
// Shared definitions for the program loader: FSM state encoding, byte width,
// address/counter width, and helpers that derive the bytes-per-word figure
// (BYTES_PER_WORD = BIT_WIDTH / 8) and the byte-index width from BIT_WIDTH.
// No ports; imported by tc_byte_packer and tc_program_loader.
// -----------------------------------------------------------------------------
package tc_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int unsigned BYTE_W            = 8;
  localparam int unsigned ADDR_W            = 16;
  localparam int unsigned DEFAULT_BIT_WIDTH = 16;
  localparam int unsigned DEFAULT_BIT_DEPTH = 256;

  // BYTES_PER_WORD for a given program word width.
  function automatic int unsigned bytes_per_word(input int unsigned bit_width);
    return bit_width / BYTE_W;
  endfunction

  // Byte index needs at least one bit even when a word is a single byte.
  function automatic int unsigned idx_width(input int unsigned bpw);
    return (bpw > 1) ? $clog2(bpw) : 1;
  endfunction

endpackage

// File: rtl/tc_byte_packer.sv
// -----------------------------------------------------------------------------
// tc_byte_packer
// Assembles a little-endian program word from a byte stream. The k-th byte
// pushed into a word lands in word[8k+7:8k]; bytes not yet received read as
// zero, so the word output doubles as the zero-padded flush value.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   clear_i       drop any partial word (start of load / after a flush)
//   push_i        a byte is accepted on this edge
//   byte_i        the byte being accepted
//   word_o        held bytes plus the incoming byte (combinational)
//   word_done_o   this push completes a word (combinational)
//   partial_o     bytes will still be held after this edge's push
// -----------------------------------------------------------------------------
module tc_byte_packer
  import tc_loader_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = DEFAULT_BIT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear_i,
  input  logic                 push_i,
  input  logic [BYTE_W-1:0]    byte_i,
  output logic [BIT_WIDTH-1:0] word_o,
  output logic                 word_done_o,
  output logic                 partial_o
);

  localparam int unsigned BYTES_PER_WORD = bytes_per_word(BIT_WIDTH);
  localparam int unsigned IDX_W          = idx_width(BYTES_PER_WORD);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BYTES_PER_WORD - 1);

  logic [BIT_WIDTH-1:0] data_q, data_d;
  logic [IDX_W-1:0]     idx_q, idx_d, idx_adv;

  always_comb begin
    // NOTE: every variable gets a default before any branch so that no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    word_o = data_q;
    if (push_i) begin
      for (int unsigned k = 0; k < BYTES_PER_WORD; k++) begin
        if (idx_q == IDX_W'(k)) begin
          word_o[BYTE_W*k +: BYTE_W] = byte_i;
        end
      end
    end

    word_done_o = push_i && (idx_q == LAST_IDX);

    idx_adv = idx_q;
    if (push_i) begin
      idx_adv = word_done_o ? '0 : idx_q + IDX_W'(1);
    end
    partial_o = (idx_adv != '0);

    // Bytes above the write index are kept at zero at all times; that is
    // what makes word_o a correctly padded flush word.
    data_d = data_q;
    idx_d  = idx_adv;
    if (clear_i || word_done_o) begin
      data_d = '0;
      idx_d  = '0;
    end else if (push_i) begin
      data_d = word_o;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      data_q <= '0;
      idx_q  <= '0;
    end else begin
      data_q <= data_d;
      idx_q  <= idx_d;
    end
  end

endmodule

// File: rtl/tc_program_loader.sv
// -----------------------------------------------------------------------------
// tc_program_loader
// Streams bytes into program memory words. A start pulse opens a load at
// address 0; accepted bytes are packed little-endian and each completed word
// is written through a registered one-cycle write strobe. finish ends the
// stream, flushing a zero-padded partial word if one is pending. The load
// also ends (full) once BIT_DEPTH words have been written.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start               begin (or restart) a load at address 0
//   finish              end of byte stream
//   in_data, in_valid   byte stream; in_ready accepts it
//   wr_en/addr/data     program-memory write port (registered)
//   word_count          words written in the current load
//   busy, done, full    status (busy in LOAD/FLUSH, done in DONE)
// -----------------------------------------------------------------------------
module tc_program_loader
  import tc_loader_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = DEFAULT_BIT_WIDTH,
  parameter int unsigned BIT_DEPTH = DEFAULT_BIT_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 finish,
  input  logic [BYTE_W-1:0]    in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [BIT_WIDTH-1:0] wr_data,
  output logic [ADDR_W-1:0]    word_count,
  output logic                 busy,
  output logic                 done,
  output logic                 full
);

  localparam logic [ADDR_W-1:0] DEPTH_W = ADDR_W'(BIT_DEPTH);

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    word_count_q, word_count_d, word_count_inc;
  logic                 full_q, full_d;
  logic                 wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
  logic [BIT_WIDTH-1:0] wr_data_q, wr_data_d;

  logic                 byte_accept;
  logic                 pack_clear;
  logic [BIT_WIDTH-1:0] pack_word;
  logic                 pack_word_done;
  logic                 pack_partial;
  logic                 at_last_word;

  // A pending start blocks byte acceptance so the restart sees an empty word.
  assign in_ready    = (state_q == ST_LOAD) && !start;
  assign byte_accept = in_valid && in_ready;

  tc_byte_packer #(
    .BIT_WIDTH (BIT_WIDTH)
  ) u_packer (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (pack_clear),
    .push_i      (byte_accept),
    .byte_i      (in_data),
    .word_o      (pack_word),
    .word_done_o (pack_word_done),
    .partial_o   (pack_partial)
  );

  assign word_count_inc = word_count_q + ADDR_W'(1);
  assign at_last_word   = (word_count_inc == DEPTH_W);

  always_comb begin
    state_d      = state_q;
    word_count_d = word_count_q;
    full_d       = full_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    pack_clear   = start;

    if (start) begin
      // A write already registered still drains this cycle; only the
      // partial word being assembled is abandoned.
      state_d      = ST_LOAD;
      word_count_d = '0;
      full_d       = 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (pack_word_done) begin
            wr_en_d      = 1'b1;
            wr_addr_d    = word_count_q;
            wr_data_d    = pack_word;
            word_count_d = word_count_inc;
            if (at_last_word) begin
              state_d = ST_DONE;
              full_d  = 1'b1;
            end else if (finish) begin
              // The byte that arrived with finish completed the word, so
              // nothing is left to flush.
              state_d = ST_DONE;
            end
          end else if (finish) begin
            state_d = pack_partial ? ST_FLUSH : ST_DONE;
          end
        end

        ST_FLUSH: begin
          // No byte can arrive here, so pack_word is the held bytes with
          // zeros above them.
          wr_en_d      = 1'b1;
          wr_addr_d    = word_count_q;
          wr_data_d    = pack_word;
          word_count_d = word_count_inc;
          pack_clear   = 1'b1;
          state_d      = ST_DONE;
          if (at_last_word) begin
            full_d = 1'b1;
          end
        end

        default: begin
          // IDLE and DONE hold; finish and bytes are ignored.
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      word_count_q <= '0;
      full_q       <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      word_count_q <= word_count_d;
      full_q       <= full_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign word_count = word_count_q;
  assign busy       = (state_q == ST_LOAD) || (state_q == ST_FLUSH);
  assign done       = (state_q == ST_DONE);
  assign full       = full_q;

endmodule

// File: tb/tb_tc_program_loader.sv
// -----------------------------------------------------------------------------
// tb_tc_program_loader
// Five loader instances of different width/depth share one stimulus stream.
// Each has a reference model (byte accumulator, word counter, load phase)
// that pushes expected writes into a per-instance queue; a monitor pops and
// compares whenever an instance raises wr_en, including the cycle it occurs.
// -----------------------------------------------------------------------------
module tb_tc_program_loader;

  localparam int NI = 5;

  function automatic int wid(input int i);
    case (i)
      0: return 16;
      1: return 32;
      2: return 16;
      3: return 8;
      default: return 64;
    endcase
  endfunction

  function automatic int dep(input int i);
    case (i)
      0: return 256;
      1: return 256;
      2: return 2;
      3: return 6;
      default: return 3;
    endcase
  endfunction

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       finish = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;

  logic [NI-1:0]       in_ready_w, wr_en_w, busy_w, done_w, full_w;
  logic [NI-1:0][15:0] wr_addr_w, wc_w;
  logic [NI-1:0][63:0] wr_data_w;
  logic [15:0] wd0;
  logic [31:0] wd1;
  logic [15:0] wd2;
  logic [7:0]  wd3;
  logic [63:0] wd4;

  assign wr_data_w[0] = 64'(wd0);
  assign wr_data_w[1] = 64'(wd1);
  assign wr_data_w[2] = 64'(wd2);
  assign wr_data_w[3] = 64'(wd3);
  assign wr_data_w[4] = wd4;

  tc_program_loader #(.BIT_WIDTH(16), .BIT_DEPTH(256)) dut0 (
    .clk(clk), .rst(rst), .start(start), .finish(finish), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready_w[0]), .wr_en(wr_en_w[0]),
    .wr_addr(wr_addr_w[0]), .wr_data(wd0), .word_count(wc_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .full(full_w[0]));

  tc_program_loader #(.BIT_WIDTH(32), .BIT_DEPTH(256)) dut1 (
    .clk(clk), .rst(rst), .start(start), .finish(finish), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready_w[1]), .wr_en(wr_en_w[1]),
    .wr_addr(wr_addr_w[1]), .wr_data(wd1), .word_count(wc_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .full(full_w[1]));

  tc_program_loader #(.BIT_WIDTH(16), .BIT_DEPTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .finish(finish), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready_w[2]), .wr_en(wr_en_w[2]),
    .wr_addr(wr_addr_w[2]), .wr_data(wd2), .word_count(wc_w[2]),
    .busy(busy_w[2]), .done(done_w[2]), .full(full_w[2]));

  tc_program_loader #(.BIT_WIDTH(8), .BIT_DEPTH(6)) dut3 (
    .clk(clk), .rst(rst), .start(start), .finish(finish), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready_w[3]), .wr_en(wr_en_w[3]),
    .wr_addr(wr_addr_w[3]), .wr_data(wd3), .word_count(wc_w[3]),
    .busy(busy_w[3]), .done(done_w[3]), .full(full_w[3]));

  tc_program_loader #(.BIT_WIDTH(64), .BIT_DEPTH(3)) dut4 (
    .clk(clk), .rst(rst), .start(start), .finish(finish), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready_w[4]), .wr_en(wr_en_w[4]),
    .wr_addr(wr_addr_w[4]), .wr_data(wd4), .word_count(wc_w[4]),
    .busy(busy_w[4]), .done(done_w[4]), .full(full_w[4]));

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] addr;
    logic [63:0] data;
    int unsigned cyc;
  } wr_t;

  wr_t exp_q [NI][$];

  typedef enum {M_IDLE, M_LOAD, M_FLUSH, M_DONE} mphase_e;
  mphase_e     m_ph  [NI];
  logic [63:0] m_acc [NI];
  int          m_cnt [NI];
  int          m_wc  [NI];
  bit          m_full[NI];

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected write lands on the next edge and is visible from then on.
  task automatic m_write(input int i);
    wr_t w;
    w.addr = 16'(m_wc[i]);
    w.data = m_acc[i];
    w.cyc  = cyc + 1;
    exp_q[i].push_back(w);
    m_wc[i]++;
    m_acc[i] = '0;
    m_cnt[i] = 0;
    if (m_wc[i] == dep(i)) begin
      m_ph[i]   = M_DONE;
      m_full[i] = 1'b1;
    end
  endtask

  // Effect of the upcoming rising edge given the inputs now applied.
  task automatic m_step(input int i);
    if (rst) begin
      m_ph[i] = M_IDLE; m_acc[i] = '0; m_cnt[i] = 0; m_wc[i] = 0; m_full[i] = 1'b0;
    end else if (start) begin
      m_ph[i] = M_LOAD; m_acc[i] = '0; m_cnt[i] = 0; m_wc[i] = 0; m_full[i] = 1'b0;
    end else if (m_ph[i] == M_LOAD) begin
      if (in_valid) begin
        m_acc[i] = m_acc[i] | (64'(in_data) << (8 * m_cnt[i]));
        m_cnt[i]++;
        if (m_cnt[i] == wid(i) / 8) m_write(i);
      end
      if (m_ph[i] == M_LOAD && finish) m_ph[i] = (m_cnt[i] != 0) ? M_FLUSH : M_DONE;
    end else if (m_ph[i] == M_FLUSH) begin
      m_write(i);
      m_ph[i] = M_DONE;
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < NI; i++) begin
      check($sformatf("u%0d in_ready", i), 64'(in_ready_w[i]), 64'(m_ph[i] == M_LOAD && !start));
      check($sformatf("u%0d busy", i), 64'(busy_w[i]), 64'(m_ph[i] == M_LOAD || m_ph[i] == M_FLUSH));
      check($sformatf("u%0d done", i), 64'(done_w[i]), 64'(m_ph[i] == M_DONE));
      check($sformatf("u%0d full", i), 64'(full_w[i]), 64'(m_full[i]));
      check($sformatf("u%0d word_count", i), 64'(wc_w[i]), 64'(m_wc[i]));
    end
  endtask

  task automatic cycle(input bit r, input bit s, input bit f, input bit v, input logic [7:0] d);
    @(negedge clk);
    rst = r; start = s; finish = f; in_valid = v; in_data = d;
    #1;
    if (chk_en) check_outputs();
    for (int i = 0; i < NI; i++) m_step(i);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_bytes(input logic [7:0] b [], input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0, 1'b1, b[k]);
  endtask

  // Monitor: registered outputs only change at posedge, so negedge is safe.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        wr_t w;
        if (wr_en_w[i] === 1'b1) begin
          if (exp_q[i].size() == 0) begin
            check($sformatf("u%0d unexpected wr_en addr=%0h", i, wr_addr_w[i]), 64'(wr_en_w[i]), 64'd0);
          end else begin
            w = exp_q[i].pop_front();
            check($sformatf("u%0d wr_addr", i), 64'(wr_addr_w[i]), 64'(w.addr));
            check($sformatf("u%0d wr_data", i), wr_data_w[i], w.data);
            check($sformatf("u%0d wr cycle", i), 64'(cyc), 64'(w.cyc));
          end
        end else if (exp_q[i].size() != 0) begin
          w = exp_q[i][0];
          if (w.cyc <= cyc) begin
            void'(exp_q[i].pop_front());
            check($sformatf("u%0d missing write addr=%0h", i, w.addr), 64'(wr_en_w[i]), 64'd1);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b [];
    for (int i = 0; i < NI; i++) begin
      m_ph[i] = M_IDLE; m_acc[i] = '0; m_cnt[i] = 0; m_wc[i] = 0; m_full[i] = 1'b0;
    end

    // Reset, then confirm the reset state of every output.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    chk_en = 1'b1;
    idle(1);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("u%0d reset wr_en", i), 64'(wr_en_w[i]), 64'd0);
      check($sformatf("u%0d reset wr_addr", i), 64'(wr_addr_w[i]), 64'd0);
      check($sformatf("u%0d reset wr_data", i), wr_data_w[i], 64'd0);
    end

    // Back-to-back 16-bit words.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    b = '{8'h34, 8'h12, 8'h78, 8'h56};
    send_bytes(b, 4);
    idle(2);
    check("two_words word_count", 64'(wc_w[0]), 64'd2);

    // 32-bit partial word flushed with zero padding.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    b = '{8'hAA, 8'hBB, 8'hCC};
    send_bytes(b, 3);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    idle(3);
    check("flush done", 64'(done_w[1]), 64'd1);
    check("flush full", 64'(full_w[1]), 64'd0);
    check("flush word_count", 64'(wc_w[1]), 64'd1);

    // Depth-2 instance fills; the fifth byte is refused.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_bytes(b, 5);
    idle(1);
    check("full full", 64'(full_w[2]), 64'd1);
    check("full done", 64'(done_w[2]), 64'd1);
    check("full in_ready", 64'(in_ready_w[2]), 64'd0);
    check("full word_count", 64'(wc_w[2]), 64'd2);

    // Byte coincident with finish completes the word: no flush.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h11);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'h22);
    idle(3);
    check("coincident word_count", 64'(wc_w[0]), 64'd1);
    check("coincident done", 64'(done_w[0]), 64'd1);

    // Abandoned partial word via reset, then via start.
    for (int v = 0; v < 2; v++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      b = '{8'hE1, 8'hE2};
      send_bytes(b, 2);
      if (v == 0) begin
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      end else begin
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      end
      check($sformatf("abandon%0d word_count", v), 64'(wc_w[1]), 64'd0);
      b = '{8'h01, 8'h02, 8'h03, 8'h04};
      send_bytes(b, 4);
      idle(2);
      check($sformatf("abandon%0d reload word_count", v), 64'(wc_w[1]), 64'd1);
    end

    // Write in flight when start arrives still completes.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    b = '{8'h9A, 8'hBC};
    send_bytes(b, 2);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    idle(2);
    check("inflight word_count", 64'(wc_w[0]), 64'd0);

    // 8-bit words: one write per cycle.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    b = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
    send_bytes(b, 4);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    idle(2);
    check("byte_words word_count", 64'(wc_w[3]), 64'd4);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      cycle(($urandom_range(199) == 0), ($urandom_range(39) == 0),
            ($urandom_range(24) == 0), ($urandom_range(3) != 0),
            8'($urandom));
    end

    idle(4);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("u%0d outstanding writes", i), 64'(exp_q[i].size()), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
